audio_frame_sequencer: RTL and testbench
========================================

# audio_frame_sequencer

Per-frame scheduler for the karaoke audio path, clocked by `audio_clk`. On each audio frame tick it performs a fixed sequence of stream transfers:
- pop one instrumental sample from the HPS wav FIFO and one processed-vocal sample from the HPS aout FIFO;
- push them to the left and right DAC FIFOs;
- pop one ADC sample and push it to the HPS ain FIFO.

It replaces free-running pass-through gating with an explicit FSM. It substitutes silence on underrun and keeps saturating fault counters for software.

## Interface
- `DATA_W`, default 32, sample word width.
- `CNT_W`, default 16, width of each fault counter.

- `audio_clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `play_in` in 1: enable; when low, the block is idle.
- `sample_tick` in 1: one-cycle frame pulse, already synchronous to `audio_clk`.
- `cnt_clear_in` in 1: one-cycle pulse that zeroes all counters.
- `hps_wav_valid_in` in 1, `hps_wav_ready_out` out 1, `hps_wav_data_in` in DATA_W: instrumental source.
- `hps_aout_valid_in` in 1, `hps_aout_ready_out` out 1, `hps_aout_data_in` in DATA_W: processed-vocal source.
- `dacL_valid_out` out 1, `dacL_ready_in` in 1, `dacL_data_out` out DATA_W: left DAC sink.
- `dacR_valid_out` out 1, `dacR_ready_in` in 1, `dacR_data_out` out DATA_W: right DAC sink.
- `adc_valid_in` in 1, `adc_ready_out` out 1, `adc_data_in` in DATA_W: mic source.
- `hps_ain_valid_out` out 1, `hps_ain_ready_in` in 1, `hps_ain_data_out` out DATA_W: mic sink to HPS.
- `busy_out` out 1: high in any state other than IDLE.
- `wav_underrun_cnt` out CNT_W, `aout_underrun_cnt` out CNT_W, `adc_miss_cnt` out CNT_W, `frame_late_cnt` out CNT_W: fault counters.

## Operation
FSM states: IDLE, FETCH, WRITE, CAPTURE, AIN_PUSH. A transfer occurs on any edge where valid and ready are both high.

- **IDLE:** `sample_tick` && `play_in` -> FETCH.
- **FETCH (1 cycle):**
  - `hps_wav_ready_out` = `hps_aout_ready_out` = 1.
  - Each channel latches its data if its valid is high. Otherwise it latches 0 and increments its underrun counter.
  - Next state: WRITE.
- **WRITE:**
  - `dacL_valid_out` / `dacR_valid_out` are high with the latched data.
  - Each side drops its valid independently, on the cycle after its own transfer.
  - Once both sides have transferred -> CAPTURE.
- **CAPTURE (1 cycle):**
  - `adc_ready_out` = 1.
  - If `adc_valid_in`: latch `adc_data_in` into `hps_ain_data_out` and go to AIN_PUSH.
  - Otherwise: increment `adc_miss_cnt` and go to IDLE.
- **AIN_PUSH:** `hps_ain_valid_out` = 1 until transferred, then IDLE.
- **Late tick:** `sample_tick` in any non-IDLE state with `play_in` high:
  - increment `frame_late_cnt`;
  - abandon the pending DAC/ain pushes, which drops their valids;
  - go to FETCH on the next edge.
- **`play_in` low:** from any state, go to IDLE on the next edge. All valids and readies go low at that edge; counters and data registers hold.
- **Counters:** saturate at all-ones. `cnt_clear_in` has priority over a same-cycle increment.
- **Output hold:** data outputs keep their last value outside their valid windows. Readies and valids are decoded from registered state plus per-side done flags; no input-to-output combinational paths.

## Timing
- **Reset:** all outputs are 0, including data, valids, readies, counters and `busy_out`; state is IDLE.
- **Nominal sequence, tick at cycle T:**
  - T+1: FETCH, source readies high.
  - T+2: WRITE, DAC valids high.
  - T+3: CAPTURE, if both DACs accepted at T+2.
  - T+4: AIN_PUSH.
  - T+5: IDLE, if the HPS accepts at T+4.
- **Minimum frame period:** 5 cycles; tick spacing of 5 or more cycles with all sinks ready produces no late count.
- **Reset mid-frame:** the asynchronous clear applies immediately; the in-flight sample is lost.
- **Tick in AIN_PUSH on the same cycle as the HPS transfer:** the transfer completes, the late count still increments, and the next state is FETCH.

## Test plan
- **Nominal:** `play_in`=1, all valid/ready=1, wav=0x11110000, aout=0x22220000, adc=0x33330000, one tick.
  - Required: DAC L/R and ain carry these words at T+2/T+2/T+4.
  - Required: `busy_out` high T+1..T+4; all counters 0.
- **Underrun:** `hps_wav_valid_in`=0 at FETCH.
  - Required: `dacL_data_out`=0 with valid at T+2; `wav_underrun_cnt`=1; aout path unaffected.
- **Back-pressure:** `dacR_ready_in` low for 3 cycles.
  - Required: dacL valid only at T+2, dacR valid T+2..T+5; CAPTURE at T+6.
- **Late tick:** second tick while `hps_ain_ready_in`=0 in AIN_PUSH.
  - Required: `frame_late_cnt`=1, `hps_ain_valid_out` drops, FETCH next cycle.
- **Play abort:** `play_in` drops during WRITE.
  - Required: IDLE next edge, all valids/readies 0, further ticks ignored.
- **Saturation/clear:** use CNT_W=2 and 5 ADC misses.
  - Required: `adc_miss_cnt`=3.
  - Required: `cnt_clear_in` coincident with a miss leaves it at 0.

Source files
------------

// File: rtl/audio_frame_sequencer.sv
// audio_frame_sequencer: per-frame FSM moving HPS/ADC samples to DAC and HPS FIFOs,
// substituting silence on underrun and keeping saturating fault counters.
module audio_frame_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              audio_clk,
  input  logic              reset_n,
  input  logic              play_in,
  input  logic              sample_tick,
  input  logic              cnt_clear_in,
  input  logic              hps_wav_valid_in,
  output logic              hps_wav_ready_out,
  input  logic [DATA_W-1:0] hps_wav_data_in,
  input  logic              hps_aout_valid_in,
  output logic              hps_aout_ready_out,
  input  logic [DATA_W-1:0] hps_aout_data_in,
  output logic              dacL_valid_out,
  input  logic              dacL_ready_in,
  output logic [DATA_W-1:0] dacL_data_out,
  output logic              dacR_valid_out,
  input  logic              dacR_ready_in,
  output logic [DATA_W-1:0] dacR_data_out,
  input  logic              adc_valid_in,
  output logic              adc_ready_out,
  input  logic [DATA_W-1:0] adc_data_in,
  output logic              hps_ain_valid_out,
  input  logic              hps_ain_ready_in,
  output logic [DATA_W-1:0] hps_ain_data_out,
  output logic              busy_out,
  output logic [CNT_W-1:0]  wav_underrun_cnt,
  output logic [CNT_W-1:0]  aout_underrun_cnt,
  output logic [CNT_W-1:0]  adc_miss_cnt,
  output logic [CNT_W-1:0]  frame_late_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, CAPTURE, AIN_PUSH} state_t;
  state_t state;
  logic l_done, r_done, l_xfer, r_xfer, l_fin, r_fin, late;
  logic wav_inc, aout_inc, miss_inc;
  assign hps_wav_ready_out  = state == FETCH;
  assign hps_aout_ready_out = state == FETCH;
  assign dacL_valid_out     = state == WRITE && !l_done;
  assign dacR_valid_out     = state == WRITE && !r_done;
  assign adc_ready_out      = state == CAPTURE;
  assign hps_ain_valid_out  = state == AIN_PUSH;
  assign busy_out           = state != IDLE;
  assign l_xfer   = dacL_valid_out && dacL_ready_in;
  assign r_xfer   = dacR_valid_out && dacR_ready_in;
  assign l_fin    = l_done || l_xfer;
  assign r_fin    = r_done || r_xfer;
  assign late     = sample_tick && play_in && state != IDLE;
  assign wav_inc  = play_in && state == FETCH && !hps_wav_valid_in;
  assign aout_inc = play_in && state == FETCH && !hps_aout_valid_in;
  assign miss_inc = play_in && state == CAPTURE && !adc_valid_in;
  // Clear beats a same-cycle increment; counters stick at all-ones
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    return clr ? '0 : (inc && !(&c)) ? c + 1'b1 : c;
  endfunction
  always_ff @(posedge audio_clk or negedge reset_n)
    if (!reset_n) begin
      state            <= IDLE;
      l_done           <= 1'b0;
      r_done           <= 1'b0;
      dacL_data_out    <= '0;
      dacR_data_out    <= '0;
      hps_ain_data_out <= '0;
    end else if (!play_in) begin
      state  <= IDLE;
      l_done <= 1'b0;
      r_done <= 1'b0;
    end else begin
      l_done <= state == WRITE && !late && l_fin;
      r_done <= state == WRITE && !late && r_fin;
      if (state == FETCH) begin
        dacL_data_out <= hps_wav_valid_in ? hps_wav_data_in : '0;
        dacR_data_out <= hps_aout_valid_in ? hps_aout_data_in : '0;
      end
      if (state == CAPTURE && adc_valid_in) hps_ain_data_out <= adc_data_in;
      if (late) state <= FETCH;
      else
        case (state)
          IDLE:     if (sample_tick) state <= FETCH;
          FETCH:    state <= WRITE;
          WRITE:    if (l_fin && r_fin) state <= CAPTURE;
          CAPTURE:  state <= adc_valid_in ? AIN_PUSH : IDLE;
          AIN_PUSH: if (hps_ain_ready_in) state <= IDLE;
          default:  state <= IDLE;
        endcase
    end
  always_ff @(posedge audio_clk or negedge reset_n)
    if (!reset_n) begin
      wav_underrun_cnt  <= '0;
      aout_underrun_cnt <= '0;
      adc_miss_cnt      <= '0;
      frame_late_cnt    <= '0;
    end else begin
      wav_underrun_cnt  <= bump(wav_underrun_cnt, wav_inc, cnt_clear_in);
      aout_underrun_cnt <= bump(aout_underrun_cnt, aout_inc, cnt_clear_in);
      adc_miss_cnt      <= bump(adc_miss_cnt, miss_inc, cnt_clear_in);
      frame_late_cnt    <= bump(frame_late_cnt, late, cnt_clear_in);
    end
endmodule

// File: tb/tb_audio_frame_sequencer.sv
// tb_audio_frame_sequencer: directed frames with a scoreboard of expected sink words.
module tb_audio_frame_sequencer;
  localparam int DW = 32;
  localparam int CW = 2;
  logic clk = 1'b0, reset_n = 1'b0, play_in = 1'b1, sample_tick = 1'b0, cnt_clear_in = 1'b0;
  logic wav_v = 1'b1, wav_r, aout_v = 1'b1, aout_r, dl_v, dl_r = 1'b1, dr_v, dr_r = 1'b1;
  logic adc_v = 1'b1, adc_r, ain_v, ain_r = 1'b1, busy;
  logic [DW-1:0] wav_d = '0, aout_d = '0, adc_d = '0, dl_d, dr_d, ain_d;
  logic [CW-1:0] wav_cnt, aout_cnt, miss_cnt, late_cnt;
  logic [31:0] ql[$], qr[$], qa[$];
  int total = 0, bad = 0;

  audio_frame_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .audio_clk(clk), .reset_n(reset_n), .play_in(play_in), .sample_tick(sample_tick),
    .cnt_clear_in(cnt_clear_in),
    .hps_wav_valid_in(wav_v), .hps_wav_ready_out(wav_r), .hps_wav_data_in(wav_d),
    .hps_aout_valid_in(aout_v), .hps_aout_ready_out(aout_r), .hps_aout_data_in(aout_d),
    .dacL_valid_out(dl_v), .dacL_ready_in(dl_r), .dacL_data_out(dl_d),
    .dacR_valid_out(dr_v), .dacR_ready_in(dr_r), .dacR_data_out(dr_d),
    .adc_valid_in(adc_v), .adc_ready_out(adc_r), .adc_data_in(adc_d),
    .hps_ain_valid_out(ain_v), .hps_ain_ready_in(ain_r), .hps_ain_data_out(ain_d),
    .busy_out(busy), .wav_underrun_cnt(wav_cnt), .aout_underrun_cnt(aout_cnt),
    .adc_miss_cnt(miss_cnt), .frame_late_cnt(late_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic pop_chk(input string n, input logic [31:0] a, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected transfer got %h expected none", n, a);
    end else chk(n, a, q.pop_front());
  endtask

  // Monitor: every sink handshake pops the oldest expected word for that sink
  always @(negedge clk)
    if (reset_n) begin
      if (dl_v && dl_r) pop_chk("dacL_xfer", dl_d, ql);
      if (dr_v && dr_r) pop_chk("dacR_xfer", dr_d, qr);
      if (ain_v && ain_r) pop_chk("ain_xfer", ain_d, qa);
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_strobes", {26'b0, wav_r, aout_r, dl_v, dr_v, adc_r, ain_v}, 0);
    chk("rst_data", dl_d | dr_d | ain_d, 0);
    chk("rst_cnts", {24'b0, wav_cnt, aout_cnt, miss_cnt, late_cnt}, 0);
    reset_n = 1'b1;
    step();
    // Nominal frame
    wav_d = 32'h1111_0000; aout_d = 32'h2222_0000; adc_d = 32'h3333_0000;
    ql.push_back(32'h1111_0000); qr.push_back(32'h2222_0000); qa.push_back(32'h3333_0000);
    tick();
    chk("nom_t1_busy", {31'b0, busy}, 1);
    chk("nom_t1_src_ready", {30'b0, wav_r, aout_r}, 2'b11);
    chk("nom_t1_dac_valid", {30'b0, dl_v, dr_v}, 0);
    step();
    chk("nom_t2_dac_valid", {30'b0, dl_v, dr_v}, 2'b11);
    chk("nom_t2_src_ready", {30'b0, wav_r, aout_r}, 0);
    step();
    chk("nom_t3_adc_ready", {31'b0, adc_r}, 1);
    chk("nom_t3_dac_valid", {30'b0, dl_v, dr_v}, 0);
    step();
    chk("nom_t4_ain_valid", {31'b0, ain_v}, 1);
    chk("nom_t4_busy", {31'b0, busy}, 1);
    step();
    chk("nom_t5_busy", {31'b0, busy}, 0);
    chk("nom_t5_ain_valid", {31'b0, ain_v}, 0);
    chk("nom_cnts", {24'b0, wav_cnt, aout_cnt, miss_cnt, late_cnt}, 0);
    // Underrun on the wav channel
    aout_d = 32'h2222_0001; adc_d = 32'h3333_0001;
    ql.push_back(32'h0); qr.push_back(32'h2222_0001); qa.push_back(32'h3333_0001);
    tick();
    wav_v = 1'b0;
    step();
    wav_v = 1'b1;
    chk("und_dacL_valid", {31'b0, dl_v}, 1);
    chk("und_dacL_data", dl_d, 0);
    chk("und_dacR_data", dr_d, 32'h2222_0001);
    chk("und_wav_cnt", {30'b0, wav_cnt}, 1);
    chk("und_aout_cnt", {30'b0, aout_cnt}, 0);
    step(); step(); step();
    chk("und_idle", {31'b0, busy}, 0);
    // Back-pressure on the right DAC
    wav_d = 32'h4444_0000; aout_d = 32'h5555_0000; adc_d = 32'h6666_0000;
    ql.push_back(32'h4444_0000); qr.push_back(32'h5555_0000); qa.push_back(32'h6666_0000);
    tick();
    dr_r = 1'b0;
    step();
    chk("bp_t2_valids", {30'b0, dl_v, dr_v}, 2'b11);
    step();
    chk("bp_t3_valids", {30'b0, dl_v, dr_v}, 2'b01);
    step();
    chk("bp_t4_valids", {30'b0, dl_v, dr_v}, 2'b01);
    step();
    chk("bp_t5_valids", {30'b0, dl_v, dr_v}, 2'b01);
    dr_r = 1'b1;
    step();
    chk("bp_t6_adc_ready", {31'b0, adc_r}, 1);
    chk("bp_t6_dacR_valid", {31'b0, dr_v}, 0);
    step(); step();
    chk("bp_idle", {31'b0, busy}, 0);
    // Late tick while the HPS stalls the ain push
    wav_d = 32'h7777_0001; aout_d = 32'h7777_0002; adc_d = 32'h7777_0003;
    ql.push_back(32'h7777_0001); qr.push_back(32'h7777_0002);
    ain_r = 1'b0;
    tick();
    step(); step(); step();
    chk("late_t4_ain_valid", {31'b0, ain_v}, 1);
    chk("late_t4_ain_data", ain_d, 32'h7777_0003);
    wav_d = 32'h8888_0001; aout_d = 32'h8888_0002; adc_d = 32'h8888_0003;
    ql.push_back(32'h8888_0001); qr.push_back(32'h8888_0002); qa.push_back(32'h8888_0003);
    tick();
    ain_r = 1'b1;
    chk("late_cnt", {30'b0, late_cnt}, 1);
    chk("late_ain_dropped", {31'b0, ain_v}, 0);
    chk("late_fetch", {30'b0, wav_r, aout_r}, 2'b11);
    step(); step(); step();
    chk("late_2nd_ain_valid", {31'b0, ain_v}, 1);
    step();
    chk("late_2nd_idle", {31'b0, busy}, 0);
    chk("late_cnt_hold", {30'b0, late_cnt}, 1);
    // play_in dropped during WRITE
    wav_d = 32'h9999_0001; aout_d = 32'h9999_0002;
    tick();
    step();
    chk("abort_write", {30'b0, dl_v, dr_v}, 2'b11);
    play_in = 1'b0; dl_r = 1'b0; dr_r = 1'b0;
    step();
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_strobes", {26'b0, wav_r, aout_r, dl_v, dr_v, adc_r, ain_v}, 0);
    chk("abort_hold_data", dl_d, 32'h9999_0001);
    tick();
    step();
    chk("abort_tick_ignored", {31'b0, busy}, 0);
    play_in = 1'b1; dl_r = 1'b1; dr_r = 1'b1;
    // ADC misses saturate a 2-bit counter
    adc_v = 1'b0;
    wav_d = 32'hAAAA_0001; aout_d = 32'hAAAA_0002;
    for (int i = 0; i < 5; i++) begin
      ql.push_back(32'hAAAA_0001); qr.push_back(32'hAAAA_0002);
      tick();
      step(); step(); step();
    end
    chk("sat_miss_cnt", {30'b0, miss_cnt}, 3);
    ql.push_back(32'hAAAA_0001); qr.push_back(32'hAAAA_0002);
    tick();
    step(); step();
    chk("clr_in_capture", {31'b0, adc_r}, 1);
    cnt_clear_in = 1'b1;
    step();
    cnt_clear_in = 1'b0;
    chk("clr_miss_cnt", {30'b0, miss_cnt}, 0);
    chk("clr_other_cnts", {26'b0, wav_cnt, aout_cnt, late_cnt}, 0);
    ql.push_back(32'hAAAA_0001); qr.push_back(32'hAAAA_0002);
    tick();
    step(); step(); step();
    chk("clr_then_miss", {30'b0, miss_cnt}, 1);
    adc_v = 1'b1;
    // Asynchronous reset mid-frame
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_strobes", {26'b0, wav_r, aout_r, dl_v, dr_v, adc_r, ain_v}, 0);
    chk("arst_data", dl_d | dr_d | ain_d, 0);
    chk("arst_cnts", {30'b0, miss_cnt}, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_idle", {31'b0, busy}, 0);
    chk("q_dacL_empty", ql.size(), 0);
    chk("q_dacR_empty", qr.size(), 0);
    chk("q_ain_empty", qa.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
